// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch sequencer: FSM states, PC select codes, pending-redirect kinds.
// Pure declarations; no logic, no latency.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        FAULT
    } state_e;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_BR,
        PEND_JMP
    } pend_e;

endpackage

// File: rtl/pc_seq_wait_timer.sv
// Counts cycles spent waiting on imem; expired is combinational from the count (MAX_WAIT-1).
// clr wins over en; the count parks at the expiry value rather than wrapping.
module pc_seq_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-control FSM driving PC select/operand; optional trap entry via PC_SEQ_TRAP_EN.
// Outputs registered (decision at edge N visible in cycle N+1); imem stalls park in WAIT with redirects held pending.
module pc_sequencer #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [DATA_W-1:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              jmp_valid,
    input  logic [DATA_W-1:0] jmp_target,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_offset,
    output logic [1:0]        ps,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic              fetch_fault
`ifdef PC_SEQ_TRAP_EN
    ,
    input  logic              trap_req
`endif
);

    import pc_seq_pkg::*;

    state_e              state_q, state_d;
    pend_e               pend_q, pend_d;
    logic [DATA_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic [1:0]          ps_q, ps_d;
    logic [DATA_W-1:0]   pc_target_q, pc_target_d;
    logic                imem_req_q, imem_req_d;
    logic                flush_q, flush_d;
    logic                fetch_fault_q, fetch_fault_d;

    logic                tmr_clr;
    logic                tmr_en;
    logic                tmr_expired;

    logic                dec_jmp;
    logic                dec_br;
    logic [DATA_W-1:0]   dec_jmp_tgt;
    logic [DATA_W-1:0]   dec_br_tgt;

    // A redirect arriving in the same cycle as the ack is newer than the pending one.
    assign dec_jmp     = jmp_valid || (pend_q == PEND_JMP);
    assign dec_jmp_tgt = jmp_valid ? jmp_target : pend_tgt_q;
    assign dec_br      = br_taken || (pend_q == PEND_BR);
    assign dec_br_tgt  = br_taken ? br_offset : pend_tgt_q;

    pc_seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        ps_d          = PS_HOLD;
        pc_target_d   = pc_target_q;
        flush_d       = 1'b0;
        fetch_fault_d = fetch_fault_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (imem_ack) begin
                    state_d = FETCH;
                    tmr_clr = 1'b1;
                    pend_d  = PEND_NONE;
                    if (dec_jmp) begin
                        ps_d        = PS_LOAD;
                        pc_target_d = dec_jmp_tgt;
                        flush_d     = 1'b1;
                    end else if (dec_br) begin
                        ps_d        = PS_REL;
                        pc_target_d = dec_br_tgt;
                        flush_d     = 1'b1;
                    end else if (!stall) begin
                        ps_d = PS_INC;
                    end
                end else begin
                    // A jump may replace a pending branch, never the reverse.
                    if (jmp_valid) begin
                        pend_d     = PEND_JMP;
                        pend_tgt_d = jmp_target;
                    end else if (br_taken && (pend_q != PEND_JMP)) begin
                        pend_d     = PEND_BR;
                        pend_tgt_d = br_offset;
                    end
                    if (state_q == FETCH) begin
                        state_d = WAIT;
                        tmr_en  = 1'b1;
                    end else if (tmr_expired) begin
                        state_d       = FAULT;
                        fetch_fault_d = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

`ifdef PC_SEQ_TRAP_EN
        if (trap_req && (state_q != IDLE)) begin
            state_d       = FETCH;
            pend_d        = PEND_NONE;
            ps_d          = PS_LOAD;
            pc_target_d   = TRAP_VECTOR;
            flush_d       = 1'b1;
            fetch_fault_d = 1'b0;
            tmr_clr       = 1'b1;
            tmr_en        = 1'b0;
        end
`endif

        imem_req_d = (state_d == FETCH) || (state_d == WAIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_q        <= PEND_NONE;
            pend_tgt_q    <= '0;
            ps_q          <= PS_HOLD;
            pc_target_q   <= '0;
            imem_req_q    <= 1'b0;
            flush_q       <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_tgt_q    <= pend_tgt_d;
            ps_q          <= ps_d;
            pc_target_q   <= pc_target_d;
            imem_req_q    <= imem_req_d;
            flush_q       <= flush_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign ps          = ps_q;
    assign pc_target   = pc_target_q;
    assign imem_req    = imem_req_q;
    assign flush       = flush_q;
    assign fetch_fault = fetch_fault_q;

endmodule
